// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls, multi-cycle
// divide stall sequencing and exception flush for a five-stage pipeline.
module hazard_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       jalrD,
  input  logic       divE,
  input  logic       exceptM,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallPC,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushF,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       div_busy,
  output logic       div_ready
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lwstall;
  logic brstall;
  logic divstall;
  logic br_any;

  // $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Branches compare both sources; jr/jalr only read rs.
  function automatic logic br_src_hit(input logic [REG_W-1:0] wr,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt,
                                      input logic             use_rt);
    return reg_match(wr, rs) || (use_rt && reg_match(wr, rt));
  endfunction

  assign forwardAD = regwriteM & reg_match(rsD, writeregM);
  assign forwardBD = regwriteM & reg_match(rtD, writeregM);

  always_comb begin
    forwardAE = FWD_REG;
    if (regwriteM && reg_match(rsE, writeregM)) begin
      forwardAE = FWD_M;
    end else if (regwriteW && reg_match(rsE, writeregW)) begin
      forwardAE = FWD_W;
    end
  end

  always_comb begin
    forwardBE = FWD_REG;
    if (regwriteM && reg_match(rtE, writeregM)) begin
      forwardBE = FWD_M;
    end else if (regwriteW && reg_match(rtE, writeregW)) begin
      forwardBE = FWD_W;
    end
  end

  assign lwstall = memtoregE & (reg_match(rtE, rsD) | reg_match(rtE, rtD));

  assign br_any  = branchD | jrD | jalrD;
  assign brstall = br_any &
                   ((regwriteE & br_src_hit(writeregE, rsD, rtD, branchD)) |
                    (memtoregM & br_src_hit(writeregM, rsD, rtD, branchD)));

  assign divstall  = ((state_q == IDLE) & divE) | (state_q == BUSY);
  assign div_busy  = divstall;
  assign div_ready = (state_q == DONE);

  // Divider sequencer next state; an exception aborts any divide in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (exceptM) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (divE) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(1);
          end
        end
        BUSY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall/flush priority: exception, then divide, then load-use/branch.
  always_comb begin
    stallPC = 1'b0;
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    stallW  = 1'b0;
    flushF  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    flushW  = 1'b0;
    if (exceptM) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (divstall) begin
      stallPC = 1'b1;
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallE  = 1'b1;
      flushM  = 1'b1;
    end else if (lwstall || brstall) begin
      stallPC = 1'b1;
      stallF  = 1'b1;
      stallD  = 1'b1;
      flushE  = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jrD, jalrD, divE, exceptM;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       stallPC, stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic       div_busy, div_ready;

  int errors;
  int checks;

  hazard_unit #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jrD(jrD), .jalrD(jalrD),
    .divE(divE), .exceptM(exceptM),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallPC(stallPC), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .div_ready(div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] stalls();
    return {stallPC, stallF, stallD, stallE, stallM, stallW};
  endfunction

  function automatic logic [4:0] flushes();
    return {flushF, flushD, flushE, flushM, flushW};
  endfunction

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0;
    branchD = 1'b0; jrD = 1'b0; jalrD = 1'b0;
    divE = 1'b0; exceptM = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds divE from an idle FSM and measures the stall window.
  task automatic run_div(input string tag);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b1;
    divE = 1'b1;
    #1;
    while (stallE === 1'b1 && n < 40) begin
      if (flushM !== 1'b1 || flushE !== 1'b0 || div_busy !== 1'b1 || div_ready !== 1'b0)
        ok = 1'b0;
      n++;
      step();
    end
    check({tag, "_len"}, 32'(n), 32'd32);
    check({tag, "_window"}, 32'(ok), 32'd1);
    check({tag, "_ready"}, 32'(div_ready), 32'd1);
    check({tag, "_done_stallE"}, 32'(stallE), 32'd0);
    divE = 1'b0;
    step();
    check({tag, "_idle_ready"}, 32'(div_ready), 32'd0);
    check({tag, "_idle_busy"}, 32'(div_busy), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_inputs();
    rst = 1'b0;
    #2;
    check("rst_busy", 32'(div_busy), 32'd0);
    check("rst_ready", 32'(div_ready), 32'd0);
    check("rst_stalls", 32'(stalls()), 32'h00);
    check("rst_flushes", 32'(flushes()), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    step();

    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    check("lw_rs_stalls", 32'(stalls()), 32'b111000);
    check("lw_rs_flushes", 32'(flushes()), 32'b00100);
    rsD = 5'd0; rtE = 5'd0;
    #1;
    check("lw_zero_stalls", 32'(stalls()), 32'h00);
    check("lw_zero_flushes", 32'(flushes()), 32'h00);
    rtE = 5'd9; rtD = 5'd9; rsD = 5'd2;
    #1;
    check("lw_rt_stallD", 32'(stallD), 32'd1);
    clear_inputs();

    regwriteM = 1'b1; regwriteW = 1'b1;
    writeregM = 5'd7; writeregW = 5'd7; rsE = 5'd7; rtE = 5'd7;
    #1;
    check("fwdAE_m", 32'(forwardAE), 32'd2);
    check("fwdBE_m", 32'(forwardBE), 32'd2);
    regwriteM = 1'b0;
    #1;
    check("fwdAE_w", 32'(forwardAE), 32'd1);
    regwriteW = 1'b0;
    #1;
    check("fwdAE_none", 32'(forwardAE), 32'd0);
    regwriteM = 1'b1; regwriteW = 1'b1;
    writeregM = 5'd0; writeregW = 5'd0; rsE = 5'd0; rtE = 5'd0;
    #1;
    check("fwdE_zero", 32'({forwardAE, forwardBE}), 32'd0);
    writeregM = 5'd4; rsD = 5'd4; rtD = 5'd6;
    #1;
    check("fwdD_a", 32'({forwardAD, forwardBD}), 32'b10);
    rsD = 5'd1; rtD = 5'd4;
    #1;
    check("fwdD_b", 32'({forwardAD, forwardBD}), 32'b01);
    clear_inputs();

    branchD = 1'b1; rsD = 5'd3; regwriteE = 1'b1; writeregE = 5'd3;
    #1;
    check("br_e_stalls", 32'(stalls()), 32'b111000);
    check("br_e_flushE", 32'(flushE), 32'd1);
    branchD = 1'b0; jrD = 1'b1; rsD = 5'd8; rtD = 5'd3;
    #1;
    check("jr_rt_nostall", 32'({stallD, flushE}), 32'd0);
    clear_inputs();
    branchD = 1'b1; rsD = 5'd1; rtD = 5'd6; memtoregM = 1'b1; writeregM = 5'd6;
    #1;
    check("br_m_rt_stall", 32'(stallD), 32'd1);
    branchD = 1'b0; jalrD = 1'b1; rsD = 5'd6; rtD = 5'd0;
    #1;
    check("jalr_m_stall", 32'(stallD), 32'd1);
    clear_inputs();

    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    run_div("div");
    clear_inputs();
    #1;

    begin
      logic seen_ready;
      seen_ready = 1'b0;
      divE = 1'b1;
      #1;
      repeat (10) step();
      exceptM = 1'b1;
      #1;
      check("exc_flushes", 32'(flushes()), 32'h1f);
      check("exc_stalls", 32'(stalls()), 32'h00);
      step();
      exceptM = 1'b0;
      divE = 1'b0;
      #1;
      check("exc_idle_busy", 32'(div_busy), 32'd0);
      repeat (35) begin
        if (div_ready === 1'b1) seen_ready = 1'b1;
        step();
      end
      check("exc_no_ready", 32'(seen_ready), 32'd0);
    end

    divE = 1'b1;
    #1;
    repeat (20) step();
    #2;
    divE = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(div_busy), 32'd0);
    check("arst_stallE", 32'(stallE), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("div_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DIV_CYCLES, default 32: number of E-stage stall cycles a DIV/DIVU occupies; legal range 2..63.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rsD, rtD, rsE, rtE  in  5 each  source register numbers in D and E.
REQ-005 writeregE, writeregM, writeregW  in  5 each  destination register in E/M/W.
REQ-006 regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  in  1 each  pipeline control from controller.
REQ-007 branchD, jrD, jalrD  in  1 each  D-stage branch/jump-register decode.
REQ-008 divE  in  1  DIV/DIVU resident in E.
REQ-009 exceptM  in  1  exception taken in M.
REQ-010 forwardAD, forwardBD  out  1 each  D-stage comparator forward from M.
REQ-011 forwardAE, forwardBE  out  2 each  E-stage ALU operand select: 00 regfile, 01 W result, 10 M result.
REQ-012 stallPC, stallF, stallD, stallE, stallM, stallW  out  1 each  hold pipeline register.
REQ-013 flushF, flushD, flushE, flushM, flushW  out  1 each  clear pipeline register.
REQ-014 div_busy, div_ready  out  1 each  divider occupied / result valid this cycle.

Function
REQ-015 Register $0 never matches: any compare with a zero source register is false.
REQ-016 forwardAD = regwriteM & (rsD==writeregM); forwardBD likewise with rtD; combinational.
REQ-017 forwardAE = 10 if regwriteM & rsE==writeregM; else 01 if regwriteW & rsE==writeregW; else 00; M has priority; forwardBE identical using rtE.
REQ-018 lwstall = memtoregE & (rtE==rsD | rtE==rtD).
REQ-019 brstall = (branchD|jrD|jalrD) & [(regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})]; for jrD/jalrD only rsD is compared.
REQ-020 FSM states IDLE, BUSY, DONE; 6-bit counter cnt.
REQ-021 IDLE & divE: cnt<=1, ->BUSY. BUSY: cnt<=cnt+1; cnt==DIV_CYCLES-1 ->DONE. DONE: ->IDLE unconditionally; divE in DONE never retriggers.
REQ-022 divstall = (IDLE & divE) | BUSY; total stalled cycles per divide = DIV_CYCLES.
REQ-023 div_busy = divstall; div_ready = 1 only in DONE.
REQ-024 divstall: stallPC=stallF=stallD=stallE=1, flushM=1, flushE=0 (lwstall/brstall ignored).
REQ-025 Else lwstall|brstall: stallPC=stallF=stallD=1, flushE=1, stallE=0.
REQ-026 stallM, stallW, flushF, flushD, flushW are 0 except under exceptM.
REQ-027 exceptM has top priority: flushF..flushW=1, all stalls 0, FSM->IDLE, cnt<=0 at next edge (divide aborted, div_ready not asserted).
REQ-028 All stall/flush/forward outputs combinational from inputs and state; no added latency.

Reset
REQ-029 rst low: FSM=IDLE, cnt=0 immediately, independent of clk.
REQ-030 During and after reset until new inputs: div_busy=0, div_ready=0; stall/flush outputs follow REQ-024..027 from IDLE.
REQ-031 Reset asserted mid-divide aborts it; first cycle after release is IDLE.

Verification
REQ-032 Load-use: memtoregE=1, rtE=5, rsD=5 -> stallPC/F/D=1, flushE=1, stallE=0; rsD=0, rtE=0 -> all 0.
REQ-033 Forward priority: regwriteM=regwriteW=1, writeregM=writeregW=rsE=7 -> forwardAE=10; regwriteM=0 -> 01.
REQ-034 Branch: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stallD=1, flushE=1; jrD=1, rtD=writeregE=3, rsD≠3 -> no stall.
REQ-035 Divide, DIV_CYCLES=32, divE held: stallE=1 for exactly 32 cycles, flushM=1 throughout, div_ready=1 on cycle 33 with stallE=0, then IDLE; concurrent lwstall masked.
REQ-036 exceptM at cnt=10 -> all five flushes 1, stalls 0 that cycle, IDLE next cycle, div_ready never pulses.
REQ-037 rst low at cnt=20 -> div_busy=0 asynchronously; after release divE=1 restarts a full 32-cycle stall.
